// File: rtl/srl_delay_checker.sv
// srl_delay_checker: drives an LFSR pattern into an external CE-gated shift-register chain
// and compares the returned tap against an internal history model, one sticky flag per lane.
module srl_delay_checker #(
    parameter int LANES     = 8,
    parameter int DELAY     = 32,
    parameter int OUT_REG   = 1,
    parameter int CE_PERIOD = 7
) (
    input  logic             clk,
    input  logic             rst,
    output logic [LANES-1:0] srl_d,
    output logic             srl_ce,
    input  logic [LANES-1:0] srl_q,
    output logic [LANES-1:0] error,
    output logic             checking
);
    typedef enum logic {FILL, CHECK} state_t;

    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("srl_delay_checker: LANES must be 1..16");
    end
    if (DELAY < 1 || DELAY > 64) begin : g_bad_delay
        $error("srl_delay_checker: DELAY must be 1..64");
    end
    if (CE_PERIOD == 1 || CE_PERIOD < 0 || CE_PERIOD > 255) begin : g_bad_ce
        $error("srl_delay_checker: CE_PERIOD must be 0 or 2..255");
    end

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [7:0]       ce_cnt_q, ce_cnt_d;
    logic             srl_ce_q, srl_ce_d;
    logic [6:0]       fill_q, fill_d;
    logic [LANES-1:0] srl_d_q, srl_d_d;
    logic [LANES-1:0] exp_q, exp_d;
    logic [LANES-1:0] error_q, error_d;
    logic [LANES-1:0] expected;
    logic [LANES-1:0] hist_q [DELAY];
    logic [LANES-1:0] hist_d [DELAY];

    always_comb begin
        lfsr_d   = srl_ce_q ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;
        ce_cnt_d = (CE_PERIOD == 0 || ce_cnt_q == 8'(CE_PERIOD - 1)) ? 8'd0 : ce_cnt_q + 8'd1;
        srl_ce_d = CE_PERIOD == 0 || ce_cnt_q != 8'(CE_PERIOD - 1);
        srl_d_d  = lfsr_d[LANES-1:0];
        hist_d[0] = srl_ce_q ? srl_d_q : hist_q[0];
        for (int k = 1; k < DELAY; k++) hist_d[k] = srl_ce_q ? hist_q[k-1] : hist_q[k];
        // the downstream output register is free-running, so the expected tap is too
        exp_d    = hist_q[DELAY-1];
        expected = OUT_REG != 0 ? exp_q : hist_q[DELAY-1];
        fill_d   = (srl_ce_q && fill_q != 7'(DELAY)) ? fill_q + 7'd1 : fill_q;
        state_d  = (state_q == FILL && (OUT_REG != 0 ? fill_q == 7'(DELAY) : fill_d == 7'(DELAY))) ? CHECK : state_q;
        error_d  = state_q == CHECK ? error_q | (srl_q ^ expected) : error_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            lfsr_q   <= 16'hACE1;
            ce_cnt_q <= '0;
            srl_ce_q <= 1'b0;
            fill_q   <= '0;
            srl_d_q  <= '0;
            exp_q    <= '0;
            error_q  <= '0;
            hist_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            ce_cnt_q <= ce_cnt_d;
            srl_ce_q <= srl_ce_d;
            fill_q   <= fill_d;
            srl_d_q  <= srl_d_d;
            exp_q    <= exp_d;
            error_q  <= error_d;
            hist_q   <= hist_d;
        end
    end

    assign srl_d    = srl_d_q;
    assign srl_ce   = srl_ce_q;
    assign error    = error_q;
    assign checking = state_q == CHECK;
endmodule

// File: tb/tb_srl_delay_checker.sv
// tb_srl_delay_checker: two checker instances (CE every 7th cycle low with output register, and
// CE always high with combinational tap) fed by behavioural SRL chains, compared to a reference model.
module tb_srl_delay_checker;
    localparam int D  = 32;
    localparam int HN = 16384;

    typedef struct {
        string      name;
        logic       r;
        logic [7:0] flip;
        int         n;
        logic [7:0] err;
        logic       chk;
        logic       dce_valid;
        logic [7:0] d;
        logic       ce;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0][7:0] sd;
    logic [1:0][7:0] sq;
    logic [1:0][7:0] er;
    logic [1:0] sce;
    logic [1:0] ck;
    int checks = 0;
    int errors = 0;

    int oreg [2] = '{1, 0};
    int cep  [2] = '{7, 0};
    int cdly [2] = '{D, D};

    // external chain: every value ever shifted in, never reset
    logic [7:0] cpush [2][HN];
    int         cc    [2];
    logic [7:0] creg  [2];

    // reference model: values shifted since the last reset, indexed by shift number
    logic [7:0]  hist    [2][HN];
    int          m_n     [2];
    int          m_sh    [2];
    int          m_full  [2];
    logic [15:0] m_lfsr  [2];
    logic [7:0]  m_d     [2];
    logic [7:0]  m_err   [2];
    logic [7:0]  m_tprev [2];
    logic        m_ce    [2];
    logic        m_chk   [2];
    int          rise    [2];
    logic        prev_ck [2];

    always #5 clk = ~clk;

    srl_delay_checker #(.LANES(8), .DELAY(D), .OUT_REG(1), .CE_PERIOD(7)) u_dut (
        .clk(clk), .rst(rst), .srl_d(sd[0]), .srl_ce(sce[0]), .srl_q(sq[0]), .error(er[0]), .checking(ck[0])
    );
    srl_delay_checker #(.LANES(8), .DELAY(D), .OUT_REG(0), .CE_PERIOD(0)) u_dut0 (
        .clk(clk), .rst(rst), .srl_d(sd[1]), .srl_ce(sce[1]), .srl_q(sq[1]), .error(er[1]), .checking(ck[1])
    );

    function automatic logic [15:0] adv(input logic [15:0] v);
        return {^(v & 16'h002D), v[15:1]};
    endfunction

    function automatic logic [7:0] mtap(input int i);
        return m_sh[i] >= D ? hist[i][m_sh[i] - D] : 8'h00;
    endfunction

    function automatic logic [7:0] ctap(input int i);
        return cc[i] >= cdly[i] ? cpush[i][cc[i] - cdly[i]] : 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic mreset(input int i);
        m_n[i]     = 0;
        m_sh[i]    = 0;
        m_full[i]  = -1;
        m_lfsr[i]  = 16'hACE1;
        m_d[i]     = 8'h00;
        m_err[i]   = 8'h00;
        m_tprev[i] = 8'h00;
        m_ce[i]    = 1'b0;
        m_chk[i]   = 1'b0;
    endtask

    // one clock: drive, compare mid-cycle, advance chain and model past the edge
    task automatic step(input logic r, input logic [7:0] flip);
        logic [7:0] cap_d [2];
        logic       cap_ce [2];
        logic [7:0] qv [2];
        logic [7:0] t;
        rst = r;
        for (int i = 0; i < 2; i++) begin
            qv[i] = (oreg[i] != 0 ? creg[i] : ctap(i)) ^ (i == 0 ? flip : 8'h00);
            sq[i] = qv[i];
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({sd[i], sce[i], ck[i], er[i]} !== {m_d[i], m_ce[i], m_chk[i], m_err[i]}) begin
                errors++;
                $display("FAIL model dut%0d cycle %0d: got d=%h ce=%b chk=%b err=%h expected d=%h ce=%b chk=%b err=%h",
                         i, m_n[i], sd[i], sce[i], ck[i], er[i], m_d[i], m_ce[i], m_chk[i], m_err[i]);
            end
            if (ck[i] && !prev_ck[i] && rise[i] < 0) rise[i] = m_n[i];
            prev_ck[i] = ck[i];
            cap_d[i]  = sd[i];
            cap_ce[i] = sce[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            creg[i] = ctap(i);
            if (cap_ce[i]) begin
                cpush[i][cc[i]] = cap_d[i];
                cc[i]++;
            end
            t = mtap(i);
            if (r) mreset(i);
            else begin
                if (m_chk[i]) m_err[i] |= qv[i] ^ (oreg[i] != 0 ? m_tprev[i] : t);
                if (m_ce[i]) begin
                    hist[i][m_sh[i]] = m_d[i];
                    m_sh[i]++;
                    m_lfsr[i] = adv(m_lfsr[i]);
                end
                m_n[i]++;
                if (m_full[i] < 0 && m_sh[i] >= D) m_full[i] = m_n[i];
                m_chk[i]   = m_full[i] >= 0 && m_n[i] >= m_full[i] + oreg[i];
                m_ce[i]    = cep[i] == 0 || (m_n[i] - 1) % cep[i] != cep[i] - 1;
                m_d[i]     = m_lfsr[i][7:0];
                m_tprev[i] = t;
            end
        end
    endtask

    initial begin
        vec_t tbl [6];
        logic ok;
        tbl[0] = '{"reset",          1'b1, 8'h00,    3, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[1] = '{"fill_inject_l0", 1'b0, 8'h01,   10, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{"ideal_2000",     1'b0, 8'h00, 1990, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{"inject_l3",      1'b0, 8'h08,    1, 8'h08, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{"sticky_l3",      1'b0, 8'h00,  300, 8'h08, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{"reset_pulse",    1'b1, 8'h00,    1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
        sq = '0;
        for (int i = 0; i < 2; i++) begin
            cc[i]      = 0;
            creg[i]    = 8'h00;
            rise[i]    = -1;
            prev_ck[i] = 1'b0;
            mreset(i);
        end
        @(posedge clk);
        #1;

        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < tbl[e].n; k++) step(tbl[e].r, k == tbl[e].n - 1 ? tbl[e].flip : 8'h00);
            chk({tbl[e].name, "_err"}, 32'(er[0]), 32'(tbl[e].err));
            chk({tbl[e].name, "_checking"}, 32'(ck[0]), 32'(tbl[e].chk));
            chk({tbl[e].name, "_dut0_err"}, 32'(er[1]), 32'h0);
            if (tbl[e].dce_valid) begin
                chk({tbl[e].name, "_srl_d"}, 32'(sd[0]), 32'(tbl[e].d));
                chk({tbl[e].name, "_srl_ce"}, 32'(sce[0]), 32'(tbl[e].ce));
            end
        end
        chk("rise_cycle_ce7_oreg1", 32'(rise[0]), 32'd39);
        chk("rise_cycle_ce0_oreg0", 32'(rise[1]), 32'd33);

        // first cycle after the reset pulse
        step(1'b0, 8'h00);
        chk("post_reset_srl_d", 32'(sd[0]), 32'hE1);
        chk("post_reset_srl_ce", 32'(sce[0]), 32'h1);
        chk("post_reset_err", 32'(er[0]), 32'h0);
        chk("post_reset_checking", 32'(ck[0]), 32'h0);
        chk("post_reset_dut0_srl_d", 32'(sd[1]), 32'hE1);

        // chain one stage short must be caught soon after checking starts
        cdly[0] = 31;
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            step(1'b0, 8'h00);
            ok = ck[0];
        end
        chk("short_chain_checking_rises", 32'(ok), 32'h1);
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            step(1'b0, 8'h00);
            ok = |er[0];
        end
        chk("short_chain_error_within_64", 32'(ok), 32'h1);

        // random resets, chain lengths and single-lane glitches against the model
        for (int r = 0; r < 6; r++) begin
            cdly[0] = $urandom_range(0, 3) == 0 ? 33 : D;
            for (int k = 0; k < $urandom_range(1, 3); k++) step(1'b1, 8'h00);
            for (int k = 0; k < $urandom_range(40, 300); k++)
                step(1'b0, $urandom_range(0, 15) == 0 ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/srl_delay_checker.md
SRL_DELAY_CHECKER -- requirements
Module: srl_delay_checker

Interface
REQ-001 Parameter LANES, default 8: number of independent 1-bit shift-register lanes driven and checked; legal range 1..16.
REQ-002 Parameter DELAY, default 32: enabled shifts from srl_d to the SRL tap; legal range 1..64.
REQ-003 Parameter OUT_REG, default 1: 1 = downstream registers the tap output every clock (free-running, not CE-gated); 0 = combinational tap.
REQ-004 Parameter CE_PERIOD, default 7: srl_ce deasserted one cycle in every CE_PERIOD cycles; 0 = srl_ce held high; legal range 0 or 2..255.
REQ-005 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port srl_d, output, LANES: data to the shift-register chain, registered.
REQ-008 Port srl_ce, output, 1: shift enable to the chain, registered.
REQ-009 Port srl_q, input, LANES: returned tap data from the chain.
REQ-010 Port error, output, LANES: sticky per-lane mismatch flags.
REQ-011 Port checking, output, 1: high while state is CHECK.

Function
REQ-012 Stimulus: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1; advances only on cycles where srl_ce is high; srl_d[i] = LFSR bit i.
REQ-013 CE generator: mod-CE_PERIOD cycle counter from 0; srl_ce low when counter = CE_PERIOD-1, else high.
REQ-014 Reference model: per-lane DELAY-deep shift history, shifting srl_d on the same edges as srl_ce high; expected = history tap DELAY-1, delayed one extra clock when OUT_REG=1.
REQ-015 States: FILL and CHECK; reset enters FILL.
REQ-016 FILL: count enabled shifts; transition to CHECK when count reaches DELAY and, for OUT_REG=1, one further clock elapses; no comparisons in FILL.
REQ-017 CHECK: each cycle, set error[i] when srl_q[i] differs from expected[i]; flags never clear except by reset.
REQ-018 CHECK is terminal; no transition back to FILL except via rst.
REQ-019 Cycles with srl_ce low: LFSR, history, and fill count hold; comparison still performed in CHECK (tap output stable).
REQ-020 Fill counter saturates at DELAY; no wrap-around.
REQ-021 Error flags update with one-cycle latency from the srl_q sample to error output.
REQ-022 LANES > 16 or DELAY out of range: elaboration error.

Reset
REQ-023 While rst high: srl_d = 0, srl_ce = 0, error = 0, checking = 0, LFSR = 16'hACE1, history = 0, counters = 0, state = FILL.
REQ-024 First cycle after rst deasserts: srl_ce = 1 (CE counter at 0), srl_d = LFSR bits of seed.
REQ-025 rst asserted mid-CHECK: identical to power-up reset; all sticky errors cleared, FILL restarts.

Verification
REQ-026 Ideal chain model (DELAY=32, OUT_REG=1, CE_PERIOD=7), 2000 cycles -> checking rises after 32 enabled shifts plus 1 clock; error stays 8'h00.
REQ-027 Bench forces srl_q[3] inverted for one cycle in CHECK -> error = 8'h08 from next cycle, held for the rest of simulation.
REQ-028 Chain model with delay 31 instead of 32 -> nonzero error within 64 cycles of checking rising.
REQ-029 CE_PERIOD=0, OUT_REG=0 -> srl_ce constantly 1 after reset; checking rises exactly 32 cycles after reset release; error = 0.
REQ-030 Reset pulsed 1 cycle while error = 8'h08 in CHECK -> next cycle error = 0, checking = 0, srl_d = 8'hE1.
REQ-031 Mismatch injected in FILL on lane 0 -> error stays 8'h00.
